// File: rtl/gpio_meter_pkg.sv
// Shared types and constants for the GPIO period meter.
// Building with GPIO_PERIOD_METER_AVG_EN averages AVG_DEPTH periods per reported result.
package gpio_meter_pkg;

   localparam int unsigned DEF_WIDTH = 24;
   localparam int unsigned AVG_DEPTH = 4;
   localparam int unsigned AVG_SHIFT = $clog2(AVG_DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2
   } state_e;

   // Result payload as seen by the GPIO register block at the default width
   typedef struct packed {
      logic [DEF_WIDTH-1:0] period;
      logic [DEF_WIDTH-1:0] high_time;
      logic                 timeout;
      logic                 overflow;
   } result_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-flop synchronizer for an asynchronous GPIO input with rise/fall pulses.
module gpio_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_rise_c,
   output logic o_fall_c
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_rise_c = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign o_fall_c = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/gpio_period_meter.sv
// Measures period and high time of an external square wave in clk cycles.
// Optional GPIO_PERIOD_METER_AVG_EN reports the mean of AVG_DEPTH periods.
module gpio_period_meter
   import gpio_meter_pkg::*;
#(
   parameter int unsigned width       = DEF_WIDTH,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             meas_in,
   input  logic [width-1:0] timeout_count,
   input  logic             ready,
   output logic             valid,
   output logic [width-1:0] period,
   output logic [width-1:0] high_time,
   output logic             timeout,
   output logic             overflow,
   output logic             lost
);

   localparam logic [width-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [width-1:0] period;
      logic [width-1:0] high_time;
      logic             timeout;
      logic             overflow;
   } res_t;

   logic             w_rise;
   logic             w_fall;
   logic             w_tmo;
   logic             w_new;
   logic             w_hs;
   res_t             w_res;

   state_e           r_state;
   logic [width-1:0] r_cnt;
   logic [width-1:0] r_hi;
   logic             r_ovf;
   res_t             r_out;
   logic             r_valid;
   logic             r_lost;

`ifdef GPIO_PERIOD_METER_AVG_EN
   localparam int unsigned     SUM_W    = width + 2;
   localparam int unsigned     IDX_W    = AVG_SHIFT;
   localparam logic [IDX_W-1:0] AVG_LAST = IDX_W'(AVG_DEPTH - 1);

   logic [SUM_W-1:0] w_sum;
   logic             w_last;
   logic [SUM_W-1:0] r_sum;
   logic [IDX_W-1:0] r_avg_idx;
   logic             r_ovf_acc;
`endif

   gpio_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .i_async  (meas_in),
      .o_rise_c (w_rise),
      .o_fall_c (w_fall)
   );

   assign w_hs = r_valid & ready;

   // Result candidate; a rise closing a period beats a coincident timeout
   always_comb begin
      w_tmo = (timeout_count != '0) && (r_cnt == timeout_count);
      w_new = 1'b0;
      w_res = '0;
`ifdef GPIO_PERIOD_METER_AVG_EN
      w_sum  = r_sum + SUM_W'(r_cnt);
      w_last = (r_avg_idx == AVG_LAST);
`endif
      if (r_state == MEASURE) begin
         if (w_rise) begin
`ifdef GPIO_PERIOD_METER_AVG_EN
            w_new          = w_last;
            w_res.period   = width'(w_sum >> AVG_SHIFT);
            w_res.overflow = r_ovf_acc | r_ovf;
`else
            w_new          = 1'b1;
            w_res.period   = r_cnt;
            w_res.overflow = r_ovf;
`endif
            w_res.high_time = r_hi;
         end else if (w_tmo) begin
            w_new         = 1'b1;
            w_res.timeout = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || !enable) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_ovf     <= 1'b0;
         r_out     <= '0;
         r_valid   <= 1'b0;
         r_lost    <= 1'b0;
`ifdef GPIO_PERIOD_METER_AVG_EN
         r_sum     <= '0;
         r_avg_idx <= '0;
         r_ovf_acc <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: r_state <= ARMED;
            ARMED: begin
               if (w_rise) begin
                  r_cnt   <= width'(1);
                  r_ovf   <= 1'b0;
                  r_state <= MEASURE;
               end
            end
            MEASURE: begin
               if (w_rise) begin
                  r_cnt <= width'(1);
                  r_ovf <= 1'b0;
`ifdef GPIO_PERIOD_METER_AVG_EN
                  r_avg_idx <= r_avg_idx + 1'b1;
                  if (w_last) begin
                     r_sum     <= '0;
                     r_ovf_acc <= 1'b0;
                  end else begin
                     r_sum     <= w_sum;
                     r_ovf_acc <= r_ovf_acc | r_ovf;
                  end
`endif
               end else if (w_tmo) begin
                  r_cnt   <= '0;
                  r_ovf   <= 1'b0;
                  r_state <= ARMED;
`ifdef GPIO_PERIOD_METER_AVG_EN
                  r_sum     <= '0;
                  r_avg_idx <= '0;
                  r_ovf_acc <= 1'b0;
`endif
               end else begin
                  if (r_cnt == CNT_MAX) r_ovf <= 1'b1;
                  else                  r_cnt <= r_cnt + 1'b1;
                  if (w_fall) r_hi <= r_cnt;
               end
            end
            default: r_state <= IDLE;
         endcase

         // Held result wins over a new one unless it is being consumed this cycle
         if (w_new && (!r_valid || w_hs)) begin
            r_out   <= w_res;
            r_valid <= 1'b1;
            r_lost  <= 1'b0;
         end else if (w_new) begin
            r_lost  <= 1'b1;
         end else if (w_hs) begin
            r_valid <= 1'b0;
            r_lost  <= 1'b0;
         end
      end
   end

   assign valid     = r_valid;
   assign period    = r_out.period;
   assign high_time = r_out.high_time;
   assign timeout   = r_out.timeout;
   assign overflow  = r_out.overflow;
   assign lost      = r_lost;

endmodule

// File: tb/tb_gpio_period_meter.sv
// Directed bench for gpio_period_meter: 24-bit instance plus a 4-bit saturation instance.
module tb_gpio_period_meter;

   logic        clk = 1'b0;
   logic        rst;
   logic        meas;
   logic        en24, en4, ready24, ready4;
   logic [23:0] tc24;
   logic [3:0]  tc4;
   logic        valid24, to24, ovf24, lost24;
   logic [23:0] period24, high24;
   logic        valid4, to4, ovf4, lost4;
   logic [3:0]  period4, high4;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   bit gen_on = 1'b0;
   int gen_hi = 3;
   int gen_lo = 5;
   int ph     = 0;

   always #5 clk = ~clk;

   gpio_period_meter #(.width(24), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .enable(en24), .meas_in(meas), .timeout_count(tc24),
      .ready(ready24), .valid(valid24), .period(period24), .high_time(high24),
      .timeout(to24), .overflow(ovf24), .lost(lost24)
   );

   gpio_period_meter #(.width(4), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .rst(rst), .enable(en4), .meas_in(meas), .timeout_count(tc4),
      .ready(ready4), .valid(valid4), .period(period4), .high_time(high4),
      .timeout(to4), .overflow(ovf4), .lost(lost4)
   );

   // Square-wave source: gen_hi cycles high then gen_lo cycles low, starting high
   initial forever begin
      @(negedge clk);
      if (gen_on) begin
         meas = (ph < gen_hi);
         ph   = (ph + 1 >= gen_hi + gen_lo) ? 0 : ph + 1;
      end else begin
         ph = 0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Negedges counted until valid is seen, capped at maxc
   task automatic wait_valid(input bit sel4, input int maxc, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(sel4 ? valid4 : valid24) && n < maxc);
   endtask

   int n;

   initial begin
      rst = 1'b0; meas = 1'b0; en24 = 1'b0; en4 = 1'b0;
      ready24 = 1'b1; ready4 = 1'b1; tc24 = '0; tc4 = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid",  64'(valid24),  0);
      chk("rst_period", 64'(period24), 0);
      chk("rst_high",   64'(high24),   0);
      chk("rst_flags",  64'({to24, ovf24, lost24}), 0);
      chk("rst_valid4", 64'(valid4),   0);
      rst = 1'b1;

      // 3 high / 5 low square wave
      en24 = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 gen_on = 1'b1;
      @(posedge meas);
      wait_valid(1'b0, 100, n);
      chk("sq_first_lat", 64'(n), 11);
      chk("sq_period",    64'(period24), 8);
      chk("sq_high",      64'(high24),   3);
      chk("sq_flags",     64'({to24, ovf24, lost24}), 0);
      wait_valid(1'b0, 100, n);
      chk("sq_spacing",   64'(n), 8);
      chk("sq_period2",   64'(period24), 8);

      // Divider with max_count=10 emulated as 11 high / 11 low
      en24 = 1'b0;
      @(posedge clk); #1 gen_on = 1'b0; meas = 1'b0; gen_hi = 11; gen_lo = 11;
      repeat (3) @(negedge clk);
      en24 = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 gen_on = 1'b1;
      @(posedge meas);
      wait_valid(1'b0, 100, n);
      chk("div_first_lat", 64'(n), 25);
      chk("div_period",    64'(period24), 22);
      chk("div_high",      64'(high24),   11);
      wait_valid(1'b0, 100, n);
      chk("div_spacing",   64'(n), 22);
      chk("div_period2",   64'(period24), 22);
      chk("div_high2",     64'(high24),   11);

      // Timeout: one rise, then held high with no further rise
      en24 = 1'b0;
      @(posedge clk); #1 gen_on = 1'b0; meas = 1'b0; gen_hi = 3; gen_lo = 5; tc24 = 24'd50;
      repeat (3) @(negedge clk);
      en24 = 1'b1;
      repeat (3) @(negedge clk);
      meas = 1'b1;
      wait_valid(1'b0, 100, n);
      chk("tmo_lat",    64'(n), 53);
      chk("tmo_flag",   64'(to24), 1);
      chk("tmo_period", 64'(period24), 0);
      chk("tmo_high",   64'(high24), 0);
      chk("tmo_ovf",    64'(ovf24), 0);
      @(negedge clk);
      meas = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 gen_on = 1'b1;
      @(posedge meas);
      wait_valid(1'b0, 100, n);
      chk("rearm_lat",    64'(n), 11);
      chk("rearm_period", 64'(period24), 8);
      chk("rearm_flag",   64'(to24), 0);

      // Backpressure across three periods
      ready24 = 1'b0;
      repeat (20) @(negedge clk);
      chk("bp_valid",  64'(valid24),  1);
      chk("bp_lost",   64'(lost24),   1);
      chk("bp_period", 64'(period24), 8);
      chk("bp_high",   64'(high24),   3);
      ready24 = 1'b1;
      @(negedge clk);
      chk("bp_hs_valid", 64'(valid24), 0);
      chk("bp_hs_lost",  64'(lost24),  0);
      ready24 = 1'b0;
      repeat (3) @(negedge clk);
      chk("bp_next_valid", 64'(valid24), 1);
      chk("bp_next_lost",  64'(lost24),  0);

      // Enable drop mid-measurement with a result held
      en24 = 1'b0;
      @(negedge clk);
      chk("en_valid",  64'(valid24),  0);
      chk("en_period", 64'(period24), 0);
      chk("en_high",   64'(high24),   0);
      chk("en_flags",  64'({to24, ovf24, lost24}), 0);
      en24 = 1'b1; ready24 = 1'b1;
      @(posedge meas);
      wait_valid(1'b0, 100, n);
      chk("en_first_lat", 64'(n), 11);
      chk("en_period2",   64'(period24), 8);

      // Reset mid-measurement while the input is low
      @(negedge meas);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_valid",  64'(valid24),  0);
      chk("mrst_period", 64'(period24), 0);
      chk("mrst_lost",   64'(lost24),   0);
      rst = 1'b1;
      @(posedge meas);
      wait_valid(1'b0, 100, n);
      chk("mrst_first_lat", 64'(n), 11);
      chk("mrst_period2",   64'(period24), 8);

      // Saturation on the 4-bit instance: 20 high / 20 low
      en24 = 1'b0;
      @(posedge clk); #1 gen_on = 1'b0; meas = 1'b0; gen_hi = 20; gen_lo = 20; en4 = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 gen_on = 1'b1;
      @(posedge meas);
      wait_valid(1'b1, 100, n);
      chk("sat_lat",     64'(n), 43);
      chk("sat_period",  64'(period4), 15);
      chk("sat_high",    64'(high4),   15);
      chk("sat_ovf",     64'(ovf4),    1);
      chk("sat_timeout", 64'(to4),     0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/gpio_period_meter.md
Name: gpio_period_meter

Overview:
- Receive-side counterpart of the GPIO clock divider: measures an externally supplied or loop-backed divided clock/square wave instead of generating one.
- Synchronizes the asynchronous input and detects its edges.
- Counts system-clock cycles per period and per high phase.
- Presents each result on a valid/ready interface to the GPIO register block; used to verify divider settings and to measure external tach/PWM signals.

Parameters:
- width, 24, width of counters and result fields (matches divider max_count width).
- SYNC_STAGES, 2, flip-flop stages in the input synchronizer (legal values 2..4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- enable  in  1  measurement enable; deassert aborts the measurement in progress
- meas_in  in  1  asynchronous signal to measure
- timeout_count  in  width  max cycles to wait for a rising edge; 0 disables timeout
- ready  in  1  consumer accepts result
- valid  out  1  result available
- period  out  width  clk cycles between consecutive rising edges
- high_time  out  width  clk cycles from rising edge to falling edge
- timeout  out  1  result flag: no rising edge within timeout_count
- overflow  out  1  result flag: counter saturated during this measurement
- lost  out  1  sticky: a result was dropped under backpressure; cleared on handshake

Behaviour:
- Reset (rst=0 at posedge clk):
  - Outputs: all outputs 0.
  - Internal: FSM IDLE, counter 0, synchronizer flops 0.
- Synchronizer and edge detect:
  - meas_in passes through SYNC_STAGES flops.
  - rise/fall = synchronized value vs. its 1-cycle-delayed copy.
  - Edges seen SYNC_STAGES+1 cycles after the input pin changes.
- FSM states:
  - IDLE: wait for enable=1 -> ARMED. enable=0 in any state -> IDLE next cycle, counter cleared, valid cleared.
  - ARMED: wait for rise.
    - On rise: cnt<=1 -> MEASURE.
    - No result is produced for the first edge.
  - MEASURE: cnt increments every cycle and saturates at all-ones; saturation sets an internal ovf bit.
    - On fall: capture hi<=cnt.
    - On rise: load result {period=cnt, high_time=hi, overflow=ovf, timeout=0}, then cnt<=1, ovf<=0, stay in MEASURE. The closing edge opens the next measurement.
    - If timeout_count!=0 and cnt==timeout_count with no rise in that cycle: load result {period=0, high_time=0, timeout=1}, cnt<=0 -> ARMED.
- Count example: high 3 cycles, low 5 cycles -> period=8, high_time=3.
- Output register:
  - A new result sets valid=1 the cycle after the completing edge/timeout.
  - Result fields stay stable while valid=1 && ready=0.
  - valid&&ready clears valid and lost.
  - New result while valid=1 && ready=0: the new result is discarded, the held result is unchanged, and lost<=1.
  - New result in the same cycle as a handshake: the new result is loaded, valid stays 1.
- Simultaneous rise and timeout in one cycle: the rise wins.
- Counter width: all arithmetic is unsigned width bits; compare saturated values with ==.

Optional Feature:
- Macro: GPIO_PERIOD_METER_AVG_EN.
- Defined:
  - period results are accumulated in a (width+2)-bit sum over 4 consecutive measurements.
  - One result is emitted per 4 periods, with period=sum>>2 and high_time from the last period.
  - overflow is set if any of the 4 periods overflowed.
  - A timeout discards the partial sum.
- Undefined: every period is reported individually, with no accumulator logic.

Decomposition:
- Package gpio_meter_pkg: state enum (IDLE, ARMED, MEASURE), result struct {period, high_time, timeout, overflow} parameterized via localparam default width 24, AVG_DEPTH=4 constant.
- Sub-module gpio_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs; reused by other GPIO inputs.

Test Plan:
- Square wave, 3 high / 5 low cycles, ready=1, timeout_count=0: no result for the first edge, then valid every 8 cycles with period=8, high_time=3, flags 0.
- Drive meas_in from clk_div with max_count=10: period=22, high_time=11 every result.
- meas_in held low after one rise, timeout_count=50: valid with timeout=1, period=0 exactly 50 cycles after the arming edge; FSM back in ARMED, and the next two rises give a normal period.
- ready=0 across three periods: first result is held unchanged and lost=1; raising ready for one cycle accepts it and clears lost.
- Saturation with width=4, high 20 / low 20 cycles: period=15, overflow=1.
- Assert rst=0, then enable=0, mid-MEASURE: all outputs 0 next cycle; after release, the first edge produces no result.
